// File: rtl/cosim_pkg.sv
// Shared types for the cosim run-control monitor: stop causes and trace ring entries.
package cosim_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ERROR   = 2'd1,
      CAUSE_HANG    = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } stop_cause_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } trace_entry_t;

   localparam int unsigned TRACE_DEPTH_DEFAULT = 16;
   localparam int unsigned TRACE_AW_DEFAULT    = $clog2(TRACE_DEPTH_DEFAULT);

endpackage

// File: rtl/cosim_trace_ring.sv
// Multi-write, single-read ring of the most recent commits; lanes are packed in order
// so only valid lanes consume slots.
module cosim_trace_ring
   import cosim_pkg::*;
#(
   parameter int unsigned  NCH   = 2,
   parameter int unsigned  DEPTH = TRACE_DEPTH_DEFAULT,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   wr_en_i,
   input  logic [NCH-1:0]         valid_i,
   input  trace_entry_t [NCH-1:0] entry_i,
   input  logic [AW-1:0]          rd_age_i,
   output trace_entry_t           rd_entry_o,
   output logic [AW:0]            count_o,
   output logic [AW:0]            pop_o
);

   trace_entry_t  ringMem [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   pop;
   logic [AW-1:0] slot [NCH];
   logic [AW+1:0] countSum;
   logic [AW-1:0] rdIdx;

   // Each valid lane lands right after all older valid lanes of the same cycle.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NCH; i++) begin
         slot[i] = wptr_q + pop[AW-1:0];
         pop     = pop + {{AW{1'b0}}, valid_i[i]};
      end
   end

   always_comb begin
      wptr_d   = wptr_q;
      count_d  = count_q;
      countSum = {1'b0, count_q} + {1'b0, pop};
      if (wr_en_i) begin
         wptr_d  = wptr_q + pop[AW-1:0];
         count_d = (countSum >= (AW+2)'(DEPTH)) ? (AW+1)'(DEPTH) : countSum[AW:0];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int i = 0; i < NCH; i++) begin
            if (valid_i[i]) ringMem[slot[i]] <= entry_i[i];
         end
      end
   end

   // Age 0 is the slot just behind the write pointer.
   assign rdIdx      = wptr_q - AW'(1) - rd_age_i;
   assign rd_entry_o = ringMem[rdIdx];
   assign count_o    = count_q;
   assign pop_o      = pop;

endmodule

// File: rtl/cosim_commit_monitor.sv
// Cosim run-control monitor: cycle/instret counters, commit trace ring and sticky stop with cause.
// Define COSIM_HANG_DETECT_EN to add the no-commit hang detector (CAUSE_HANG).
module cosim_commit_monitor
   import cosim_pkg::*;
#(
   parameter int unsigned  NCH         = 2,
   parameter int unsigned  DEPTH       = TRACE_DEPTH_DEFAULT,
   parameter logic [63:0]  MAX_CYCLES  = 64'd4000000,
   parameter int unsigned  HANG_CYCLES = 10000,
   localparam int unsigned AW          = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NCH-1:0]    commit_valid,
   input  logic [NCH*64-1:0] commit_pc,
   input  logic [NCH*32-1:0] commit_inst,
   input  logic              ext_error,
   input  logic [AW-1:0]     rd_age,
   output logic [63:0]       rd_pc,
   output logic [31:0]       rd_inst,
   output logic [AW:0]       trace_count,
   output logic [63:0]       cycle_cnt,
   output logic [63:0]       instret,
   output logic              stop,
   output logic [1:0]        stop_cause
);

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_STOPPED = 1'b1;

   logic [0:0]             state_q, state_d;
   stop_cause_e            cause_q, cause_d, causeHit;
   logic [63:0]            cycleCnt_q, cycleCnt_d;
   logic [63:0]            instret_q, instret_d;
   logic                   running;
   logic                   hangHit;
   logic [AW:0]            commitPop;
   trace_entry_t [NCH-1:0] laneEntry;
   trace_entry_t           rdEntry;

   assign running = (state_q == ST_RUN);

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         laneEntry[i].pc   = commit_pc[64*i +: 64];
         laneEntry[i].inst = commit_inst[32*i +: 32];
      end
   end

   cosim_trace_ring #(
      .NCH   (NCH),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .wr_en_i    (running),
      .valid_i    (commit_valid),
      .entry_i    (laneEntry),
      .rd_age_i   (rd_age),
      .rd_entry_o (rdEntry),
      .count_o    (trace_count),
      .pop_o      (commitPop)
   );

`ifdef COSIM_HANG_DETECT_EN
   localparam logic [31:0] HANG_LIMIT = 32'(HANG_CYCLES);
   logic [31:0] idleCnt_q, idleCnt_d;

   // Idle counter saturates at the limit so the hang condition stays asserted.
   always_comb begin
      idleCnt_d = idleCnt_q;
      if (running) begin
         if (|commit_valid)                idleCnt_d = '0;
         else if (idleCnt_q != HANG_LIMIT) idleCnt_d = idleCnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) idleCnt_q <= '0;
      else       idleCnt_q <= idleCnt_d;
   end

   assign hangHit = (idleCnt_q == HANG_LIMIT);
`else
   assign hangHit = 1'b0;
`endif

   always_comb begin
      causeHit = CAUSE_NONE;
      if (ext_error)                                             causeHit = CAUSE_ERROR;
      else if (hangHit)                                          causeHit = CAUSE_HANG;
      else if (MAX_CYCLES != 64'd0 && cycleCnt_q == MAX_CYCLES)  causeHit = CAUSE_TIMEOUT;
   end

   // The stopping cycle still counts its commits; after that everything freezes.
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      cycleCnt_d = cycleCnt_q;
      instret_d  = instret_q;
      if (running) begin
         cycleCnt_d = cycleCnt_q + 64'd1;
         instret_d  = instret_q + 64'(commitPop);
         if (causeHit != CAUSE_NONE) begin
            state_d = ST_STOPPED;
            cause_d = causeHit;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_RUN;
         cause_q    <= CAUSE_NONE;
         cycleCnt_q <= '0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         cycleCnt_q <= cycleCnt_d;
         instret_q  <= instret_d;
      end
   end

   assign rd_pc      = rdEntry.pc;
   assign rd_inst    = rdEntry.inst;
   assign cycle_cnt  = cycleCnt_q;
   assign instret    = instret_q;
   assign stop       = (state_q == ST_STOPPED);
   assign stop_cause = cause_q;

endmodule

// File: tb/tb_cosim_commit_monitor.sv
// Scoreboard bench for cosim_commit_monitor: stimulus queues hand-computed expectations,
// a monitor process drains and compares them mid-cycle.
module tb_cosim_commit_monitor;
   import cosim_pkg::*;

   localparam int unsigned NCH   = 2;
   localparam int unsigned DEPTH = TRACE_DEPTH_DEFAULT;
   localparam int unsigned AW    = TRACE_AW_DEFAULT;

   localparam int unsigned F_CYCLE   = 0;
   localparam int unsigned F_INSTRET = 1;
   localparam int unsigned F_STOP    = 2;
   localparam int unsigned F_CAUSE   = 3;
   localparam int unsigned F_COUNT   = 4;
   localparam int unsigned F_PC      = 5;
   localparam int unsigned F_INST    = 6;

   typedef struct {
      string         name;
      int unsigned   field;
      logic [AW-1:0] age;
      logic [63:0]   expected;
   } check_t;

   logic              clock;
   logic              rstn;
   logic [NCH-1:0]    commitValid;
   logic [NCH*64-1:0] commitPc;
   logic [NCH*32-1:0] commitInst;
   logic              extError;
   logic [AW-1:0]     rdAge;
   logic [63:0]       rdPc;
   logic [31:0]       rdInst;
   logic [AW:0]       traceCount;
   logic [63:0]       cycleCnt;
   logic [63:0]       instretCnt;
   logic              stop;
   logic [1:0]        stopCause;

   check_t sbQueue[$];
   check_t item;
   logic [63:0] actual;
   int compareCount  = 0;
   int mismatchCount = 0;

   cosim_commit_monitor #(
      .NCH         (NCH),
      .DEPTH       (DEPTH),
      .MAX_CYCLES  (64'd128),
      .HANG_CYCLES (8)
   ) dut (
      .clk          (clock),
      .rstn         (rstn),
      .commit_valid (commitValid),
      .commit_pc    (commitPc),
      .commit_inst  (commitInst),
      .ext_error    (extError),
      .rd_age       (rdAge),
      .rd_pc        (rdPc),
      .rd_inst      (rdInst),
      .trace_count  (traceCount),
      .cycle_cnt    (cycleCnt),
      .instret      (instretCnt),
      .stop         (stop),
      .stop_cause   (stopCause)
   );

   initial clock = 1'b0;
   always #20 clock = ~clock;

   // Hard bound on the whole run in case something never returns.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] sampleField(int unsigned f);
      case (f)
         F_CYCLE:   return cycleCnt;
         F_INSTRET: return instretCnt;
         F_STOP:    return {63'd0, stop};
         F_CAUSE:   return {62'd0, stopCause};
         F_COUNT:   return {{(63-AW){1'b0}}, traceCount};
         F_PC:      return rdPc;
         F_INST:    return {32'd0, rdInst};
         default:   return '1;
      endcase
   endfunction

   // Monitor: compares every queued expectation shortly after each falling edge.
   initial begin
      rdAge = '0;
      forever begin
         @(negedge clock);
         #1;
         while (sbQueue.size() != 0) begin
            item  = sbQueue.pop_front();
            rdAge = item.age;
            #1;
            actual = sampleField(item.field);
            compareCount++;
            if (actual !== item.expected) begin
               mismatchCount++;
               $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", item.name, actual, item.expected);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int unsigned field,
                              input int unsigned age, input logic [63:0] expected);
      check_t c;
      c.name     = name;
      c.field    = field;
      c.age      = AW'(age);
      c.expected = expected;
      sbQueue.push_back(c);
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [63:0] pc0, input logic [31:0] inst0,
                                input logic [63:0] pc1, input logic [31:0] inst1, input logic err);
      commitValid = valid;
      commitPc    = {pc1, pc0};
      commitInst  = {inst1, inst0};
      extError    = err;
      @(posedge clock);
      #1;
   endtask

   task automatic resetDut();
      @(negedge clock);
      #15;
      rstn        = 1'b0;
      commitValid = '0;
      commitPc    = '0;
      commitInst  = '0;
      extError    = 1'b0;
      checkOutput("rst_cycle",   F_CYCLE,   0, 64'd0);
      checkOutput("rst_instret", F_INSTRET, 0, 64'd0);
      checkOutput("rst_stop",    F_STOP,    0, 64'd0);
      checkOutput("rst_cause",   F_CAUSE,   0, 64'(CAUSE_NONE));
      checkOutput("rst_count",   F_COUNT,   0, 64'd0);
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      rstn        = 1'b0;
      commitValid = '0;
      commitPc    = '0;
      commitInst  = '0;
      extError    = 1'b0;

      // Single lane, 100 back-to-back commits.
      resetDut();
      for (int i = 0; i < 100; i++)
         applyStimulus(2'b01, 64'h1000 + 64'(i*4), 32'h13, 64'h0, 32'h0, 1'b0);
      checkOutput("t1_cycle",   F_CYCLE,   0,  64'd100);
      checkOutput("t1_instret", F_INSTRET, 0,  64'd100);
      checkOutput("t1_stop",    F_STOP,    0,  64'd0);
      checkOutput("t1_count",   F_COUNT,   0,  64'd16);
      checkOutput("t1_age0",    F_PC,      0,  64'h118C);
      checkOutput("t1_age15",   F_PC,      15, 64'h1150);

      // Two lanes together, then only lane 1.
      resetDut();
      applyStimulus(2'b11, 64'h8000_0000, 32'h0000_0013, 64'h8000_0004, 32'h0010_0093, 1'b0);
      applyStimulus(2'b10, 64'hDEAD_0000, 32'hFFFF_FFFF, 64'h8000_0008, 32'h0020_0113, 1'b0);
      checkOutput("t2_instret", F_INSTRET, 0, 64'd3);
      checkOutput("t2_cycle",   F_CYCLE,   0, 64'd2);
      checkOutput("t2_count",   F_COUNT,   0, 64'd3);
      checkOutput("t2_age0",    F_PC,      0, 64'h8000_0008);
      checkOutput("t2_age1",    F_PC,      1, 64'h8000_0004);
      checkOutput("t2_age2",    F_PC,      2, 64'h8000_0000);
      checkOutput("t2_inst0",   F_INST,    0, 64'h0020_0113);
      checkOutput("t2_inst2",   F_INST,    2, 64'h0000_0013);

      // 20 commits through lane 1 only; ring wraps past 16 entries.
      resetDut();
      for (int i = 0; i < 20; i++)
         applyStimulus(2'b10, 64'hBAD, 32'h0, 64'h2000 + 64'(i*4), 32'h13, 1'b0);
      checkOutput("t3_count",   F_COUNT,   0,  64'd16);
      checkOutput("t3_instret", F_INSTRET, 0,  64'd20);
      checkOutput("t3_age0",    F_PC,      0,  64'h204C);
      checkOutput("t3_age4",    F_PC,      4,  64'h203C);
      checkOutput("t3_age15",   F_PC,      15, 64'h2010);

      // Error pulse sampled at cycle 50.
      resetDut();
      for (int i = 0; i < 50; i++)
         applyStimulus(2'b01, 64'h3000 + 64'(i*4), 32'h13, 64'h0, 32'h0, 1'b0);
      checkOutput("t4_prestop", F_STOP,  0, 64'd0);
      checkOutput("t4_precyc",  F_CYCLE, 0, 64'd50);
      applyStimulus(2'b01, 64'h30C8, 32'h13, 64'h0, 32'h0, 1'b1);
      checkOutput("t4_stop",    F_STOP,    0, 64'd1);
      checkOutput("t4_cause",   F_CAUSE,   0, 64'(CAUSE_ERROR));
      checkOutput("t4_cycle",   F_CYCLE,   0, 64'd51);
      checkOutput("t4_instret", F_INSTRET, 0, 64'd51);
      for (int i = 0; i < 5; i++)
         applyStimulus(2'b11, 64'h4000 + 64'(i*8), 32'h13, 64'h4004 + 64'(i*8), 32'h13, 1'b0);
      checkOutput("t4_frzstop",  F_STOP,    0, 64'd1);
      checkOutput("t4_frzcause", F_CAUSE,   0, 64'(CAUSE_ERROR));
      checkOutput("t4_frzcyc",   F_CYCLE,   0, 64'd51);
      checkOutput("t4_frzinst",  F_INSTRET, 0, 64'd51);
      checkOutput("t4_frzage0",  F_PC,      0, 64'h30C8);
      checkOutput("t4_frzage1",  F_PC,      1, 64'h30C4);

      // Commits stop after three instructions.
      resetDut();
      for (int i = 0; i < 3; i++)
         applyStimulus(2'b01, 64'h5000 + 64'(i*4), 32'h13, 64'h0, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++)
         applyStimulus(2'b00, 64'h0, 32'h0, 64'h0, 32'h0, 1'b0);
      checkOutput("t5_prestop", F_STOP,  0, 64'd0);
      checkOutput("t5_precyc",  F_CYCLE, 0, 64'd11);
      applyStimulus(2'b00, 64'h0, 32'h0, 64'h0, 32'h0, 1'b0);
`ifdef COSIM_HANG_DETECT_EN
      checkOutput("t5_stop",  F_STOP,  0, 64'd1);
      checkOutput("t5_cause", F_CAUSE, 0, 64'(CAUSE_HANG));
`else
      checkOutput("t5_stop",  F_STOP,  0, 64'd0);
      checkOutput("t5_cause", F_CAUSE, 0, 64'(CAUSE_NONE));
`endif
      checkOutput("t5_cycle", F_CYCLE, 0, 64'd12);
      for (int i = 0; i < 10; i++)
         applyStimulus(2'b00, 64'h0, 32'h0, 64'h0, 32'h0, 1'b0);
`ifdef COSIM_HANG_DETECT_EN
      checkOutput("t5_latecyc", F_CYCLE, 0, 64'd12);
`else
      checkOutput("t5_latecyc", F_CYCLE, 0, 64'd22);
`endif
      checkOutput("t5_instret", F_INSTRET, 0, 64'd3);

      // Cycle budget alone.
      resetDut();
      for (int i = 0; i < 128; i++)
         applyStimulus(2'b01, 64'h6000 + 64'(i*4), 32'h13, 64'h0, 32'h0, 1'b0);
      checkOutput("t6_prestop", F_STOP,  0, 64'd0);
      checkOutput("t6_precyc",  F_CYCLE, 0, 64'd128);
      applyStimulus(2'b01, 64'h6200, 32'h13, 64'h0, 32'h0, 1'b0);
      checkOutput("t6_stop",    F_STOP,    0, 64'd1);
      checkOutput("t6_cause",   F_CAUSE,   0, 64'(CAUSE_TIMEOUT));
      checkOutput("t6_cycle",   F_CYCLE,   0, 64'd129);
      checkOutput("t6_instret", F_INSTRET, 0, 64'd129);
      applyStimulus(2'b01, 64'h6204, 32'h13, 64'h0, 32'h0, 1'b1);
      applyStimulus(2'b00, 64'h0, 32'h0, 64'h0, 32'h0, 1'b0);
      checkOutput("t6_latecause", F_CAUSE, 0, 64'(CAUSE_TIMEOUT));
      checkOutput("t6_latecyc",   F_CYCLE, 0, 64'd129);

      // Error and budget in the same cycle: error wins.
      resetDut();
      for (int i = 0; i < 128; i++)
         applyStimulus(2'b01, 64'h7000 + 64'(i*4), 32'h13, 64'h0, 32'h0, 1'b0);
      applyStimulus(2'b01, 64'h7200, 32'h13, 64'h0, 32'h0, 1'b1);
      checkOutput("t7_stop",  F_STOP,  0, 64'd1);
      checkOutput("t7_cause", F_CAUSE, 0, 64'(CAUSE_ERROR));
      checkOutput("t7_cycle", F_CYCLE, 0, 64'd129);

      // Reset out of the stopped state.
      resetDut();

      applyStimulus(2'b00, 64'h0, 32'h0, 64'h0, 32'h0, 1'b0);
      applyStimulus(2'b00, 64'h0, 32'h0, 64'h0, 32'h0, 1'b0);
      if (sbQueue.size() != 0) begin
         compareCount++;
         mismatchCount++;
         $display("[TB] FAIL drain: actual %0d pending required 0 pending", sbQueue.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
